grey_frame_seq: RTL
===================

GREY_FRAME_SEQ -- requirements
Module: grey_frame_seq

Interface
REQ-001 SHALL have parameter IMG_W, default 128, frame width in pixels.
REQ-002 SHALL have parameter IMG_H, default 128, frame height in pixels.
REQ-003 SHALL have parameter RD_LAT, default 2, source memory read latency in cycles (1..4).
REQ-004 SHALL have the following ports; ADDR_W = $clog2(IMG_W*IMG_H):
- clk_100mhz  in  1  sole clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins one frame conversion.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse after the last pixel is written.
- rd_addr  out  ADDR_W  source image memory address.
- rd_data  in  12  source pixel, {r[11:8], g[7:4], b[3:0]}.
- wr_addr  out  ADDR_W  destination memory address.
- wr_data  out  8  greyscale pixel.
- wr_en  out  1  destination write strobe.

Function
REQ-005 SHALL implement states IDLE, ISSUE, DRAIN, FINISH.
REQ-006 IDLE->ISSUE on start; busy SHALL assert the cycle after start is sampled.
REQ-007 In ISSUE, rd_addr SHALL start at 0 and increment by 1 per cycle until it reaches IMG_W*IMG_H-1, then the FSM SHALL go to DRAIN.
REQ-008 rd_addr SHALL never exceed IMG_W*IMG_H-1 and SHALL hold its last value outside ISSUE.
REQ-009 A valid shift register of depth RD_LAT SHALL track issued reads.
REQ-010 rd_data SHALL be sampled exactly RD_LAT cycles after its address is presented.
REQ-011 wr_en, wr_addr and wr_data SHALL be registered and valid one cycle after rd_data is sampled, so read-issue-to-write latency is RD_LAT+1 cycles.
REQ-012 wr_addr SHALL equal the rd_addr that produced the pixel; exactly IMG_W*IMG_H writes SHALL occur per frame, in ascending address order.
REQ-013 DRAIN SHALL wait until the valid pipeline is empty and the last write has been issued, then go to FINISH.
REQ-014 FINISH SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-015 start while busy SHALL be ignored (no restart, no queueing); start in the same cycle as done SHALL be ignored.
REQ-016 Greyscale computation SHALL zero-extend nibbles before summing; no intermediate overflow is permitted.
REQ-017 Default arithmetic: wr_data = (r+g+b)<<2, range 0..180.
REQ-018 Frame cycle count from start to done SHALL be IMG_W*IMG_H + RD_LAT + 2.

Reset
REQ-019 Asserting sys_rst_n low SHALL immediately force the state to IDLE and clear busy, done, wr_en, rd_addr, wr_addr, wr_data and the valid pipeline to 0.
REQ-020 Reset mid-frame SHALL abort the frame with no further writes and no done pulse.
REQ-021 Reset release SHALL be followed by IDLE awaiting start.

Configuration
REQ-022 With macro GREY_WEIGHTED_EN defined, wr_data SHALL be (r+2*g+b)<<2 (range 0..240).
REQ-023 Without GREY_WEIGHTED_EN, wr_data SHALL follow REQ-017; no other behaviour changes.

Structure
REQ-024 Package grey_pkg SHALL hold the state enum typedef, pixel field widths (4-bit channel, 12-bit pixel, 8-bit grey) and the default frame dimensions.
REQ-025 The greyscale arithmetic SHALL be a sub-module grey_px_conv (12-bit in, 8-bit out, combinational, macro-aware); sequencing stays in grey_frame_seq.

Verification
REQ-026 Bench SHALL cover these scenarios (IMG_W=IMG_H=4, RD_LAT=2, model memory with 2-cycle latency):
- Pixel value = address: start -> 16 writes at addresses 0..15, done exactly 20 cycles after start.
- rd_data=12'hFFF everywhere: wr_data=180 without the macro, 240 with GREY_WEIGHTED_EN; rd_data=12'h000 -> wr_data=0.
- rd_data=12'h1A3: wr_data=56 (default), 96 (weighted).
- start pulsed again at cycles 3 and 10 of a frame -> ignored, exactly 16 writes, one done.
- sys_rst_n low at cycle 8 of a frame -> wr_en=0 from that instant, no done; a new start then yields a full 16-write frame.
- Back-to-back frames: start the cycle after done -> second frame identical to the first, rd_addr never above 15.

Source files
------------

// File: rtl/grey_pkg.sv
// Shared types and widths for the greyscale frame sequencer.
// GREY_WEIGHTED_EN selects weighted arithmetic in grey_px_conv.
package grey_pkg;

    localparam int unsigned CH_W      = 4;
    localparam int unsigned PIX_W     = 12;
    localparam int unsigned GREY_W    = 8;
    localparam int unsigned DEF_IMG_W = 128;
    localparam int unsigned DEF_IMG_H = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/grey_px_conv.sv
// Combinational 12-bit RGB444 to 8-bit grey conversion.
// GREY_WEIGHTED_EN defined: (r + 2g + b) << 2, otherwise (r + g + b) << 2.
module grey_px_conv
    import grey_pkg::*;
(
    input  logic [PIX_W-1:0]  i_pix,
    output logic [GREY_W-1:0] o_grey
);

    // 6 bits holds the worst-case weighted sum of 60 without overflow.
    localparam int unsigned SUM_W = 6;

    logic [SUM_W-1:0] w_r;
    logic [SUM_W-1:0] w_g;
    logic [SUM_W-1:0] w_b;
    logic [SUM_W-1:0] w_sum;

    assign w_r = SUM_W'(i_pix[3*CH_W-1:2*CH_W]);
    assign w_g = SUM_W'(i_pix[2*CH_W-1:CH_W]);
    assign w_b = SUM_W'(i_pix[CH_W-1:0]);

`ifdef GREY_WEIGHTED_EN
    assign w_sum = w_r + (w_g << 1) + w_b;
`else
    assign w_sum = w_r + w_g + w_b;
`endif

    assign o_grey = {w_sum, 2'b00};

endmodule

// File: rtl/grey_frame_seq.sv
// Frame sequencer: streams every source pixel through grey_px_conv into the destination memory.
// Arithmetic variant is chosen by GREY_WEIGHTED_EN (see grey_px_conv).
module grey_frame_seq
    import grey_pkg::*;
#(
    parameter  int unsigned IMG_W  = DEF_IMG_W,
    parameter  int unsigned IMG_H  = DEF_IMG_H,
    parameter  int unsigned RD_LAT = 2,
    localparam int unsigned NPIX   = IMG_W * IMG_H,
    localparam int unsigned ADDR_W = $clog2(NPIX)
) (
    input  logic              clk_100mhz,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [GREY_W-1:0] wr_data,
    output logic              wr_en
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    state_t            r_state;
    logic [RD_LAT-1:0] r_vld;
    logic [ADDR_W-1:0] r_apipe [RD_LAT];
    logic [PIX_W-1:0]  r_pix;
    logic [GREY_W-1:0] w_grey;

    grey_px_conv u_conv (
        .i_pix  (r_pix),
        .o_grey (w_grey)
    );

    // Read-return pipeline: r_pix is captured on the same edge its tag reaches r_vld[RD_LAT-1].
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_vld   <= '0;
            r_pix   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_apipe[i] <= '0;
            end
        end else begin
            r_vld      <= (r_vld << 1) | RD_LAT'(r_state == ISSUE);
            r_apipe[0] <= rd_addr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_apipe[i] <= r_apipe[i-1];
            end
            r_pix <= rd_data;
            wr_en <= r_vld[RD_LAT-1];
            if (r_vld[RD_LAT-1]) begin
                wr_addr <= r_apipe[RD_LAT-1];
                wr_data <= w_grey;
            end
        end
    end

    // Frame control FSM; rd_addr holds its last value outside ISSUE.
    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ISSUE;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (rd_addr == LAST_ADDR) begin
                        r_state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // Pipeline empty while the final write strobe is out.
                    if ((r_vld == '0) && wr_en) begin
                        r_state <= FINISH;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
